// File: rtl/seq_110011_moore.sv
// seq_110011_moore: Moore detector for serial pattern 1-1-0-0-1-1.
// Ports: clk, reset (sync, active-high), x (serial in), z (detect flag).
// Option: define SEQ_NONOVERLAP_EN to stop bits of a match being reused.
module seq_110011_moore (
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic z
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5,
      S6 = 3'd6
   } state_t;

   state_t state_q, state_d;
   logic   z_q, z_d;

   always_comb begin
      state_d = S0;
      case (state_q)
         S0: state_d = x ? S1 : S0;
         S1: state_d = x ? S2 : S0;
         S2: state_d = x ? S2 : S3;
         S3: state_d = x ? S1 : S4;
         S4: state_d = x ? S5 : S0;
         S5: state_d = x ? S6 : S0;
`ifdef SEQ_NONOVERLAP_EN
         // A completed match is consumed whole.
         S6: state_d = x ? S1 : S0;
`else
         // Trailing "11" of a match is the head of the next.
         S6: state_d = x ? S2 : S3;
`endif
         // Encoding 7 is unreachable; recover to idle.
         default: state_d = S0;
      endcase
      if (reset) begin
         state_d = S0;
      end
   end

   // z registered alongside the state so it always equals (state_q == S6).
   always_comb begin
      z_d = (state_d == S6);
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      z_q     <= z_d;
   end

   assign z = z_q;

endmodule

// File: tb/tb_seq_110011_moore.sv
// tb_seq_110011_moore: scoreboard bench for seq_110011_moore.
// Directed bit streams with hand-derived per-edge z expectations.
module tb_seq_110011_moore;

   logic clk;
   logic reset;
   logic x;
   logic z;

   int total = 0;
   int bad = 0;

   logic  exp_q[$];
   string nm_q[$];

   seq_110011_moore dut (
      .clk   (clk),
      .reset (reset),
      .x     (x),
      .z     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every negedge, compare z with the oldest pending expectation.
   always @(negedge clk) begin
      logic  e;
      string n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         total++;
         if (z !== e) begin
            bad++;
            $display("FAIL %s: z=%b expected=%b", n, z, e);
         end
      end
   end

   task automatic step(input logic b, input logic r,
                       input logic e, input string nm);
      @(negedge clk);
      x = b;
      reset = r;
      @(posedge clk);
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic do_reset(input string nm);
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, nm);
   endtask

   // bits/expect given as '0'/'1' strings, one char per edge.
   task automatic run(input string nm, input string bits, input string ex);
      for (int i = 0; i < bits.len(); i++) begin
         step(bits[i] == "1", 1'b0, ex[i] == "1",
              $sformatf("%s[%0d]", nm, i));
      end
   endtask

   initial begin
      x = 1'b0;
      reset = 1'b0;

      do_reset("reset0");
      do_reset("reset1");
      run("rel", "0", "0");

      do_reset("rst_basic");
      run("basic", "0011001110010010", "0000000100000000");

      do_reset("rst_ovl");
`ifdef SEQ_NONOVERLAP_EN
      run("overlap", "1100110011", "0000010000");
`else
      run("overlap", "1100110011", "0000010001");
`endif

      do_reset("rst_nm1");
      run("near1", "110110011", "000000001");

      do_reset("rst_nm2");
      run("near2", "110010", "000000");
      run("near2_idle", "1", "0");

      do_reset("rst_mid0");
      run("mid", "11001", "00000");
      // x=1 here would complete the pattern without reset priority.
      step(1'b1, 1'b1, 1'b0, "mid_rst");
      run("mid_after", "1", "0");

      do_reset("rst_long");
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0, $sformatf("ones[%0d]", i));
      end
      run("ones_tail", "0011", "0001");
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, $sformatf("zeros[%0d]", i));
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
